// File: rtl/clock_pkg.sv
// Shared constants for the multimodal digital clock: display modes, field widths and limits.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_OTHER0 = 2'b00,
        MODE_CLOCK  = 2'b01,
        MODE_SET    = 2'b10,
        MODE_OTHER3 = 2'b11
    } mode_e;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 4;

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);
    localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(12);
    localparam logic [HR_W-1:0]  HR_MIN  = HR_W'(1);

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a synchronous, debounced button level.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_q <= 1'b0;
        else        r_q <= in;
    end

    assign rise = in & ~r_q;

endmodule

// File: rtl/time_keeper_12h.sv
// Free-running 12-hour timekeeper with set mode. Define EXT_TICK_EN to take the
// 1 Hz tick from the tick_1hz port instead of the internal TICK_DIV prescaler.
module time_keeper_12h
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             inc_hr,
    input  logic             inc_min,
`ifdef EXT_TICK_EN
    input  logic             tick_1hz,
`endif
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic             AP,
    output logic             sec_tick
);

    localparam logic [HR_W-1:0] HR_PRE_NOON = HR_MAX - 1'b1;

    logic [SEC_W-1:0] r_sec;
    logic [MIN_W-1:0] r_min;
    logic [HR_W-1:0]  r_hr;
    logic             r_ap;
    logic             r_sec_tick;

    logic w_set, w_tick, w_rise_hr, w_rise_min;
    logic w_sec_wrap, w_min_wrap, w_step_min, w_step_hr;

    function automatic logic [MIN_W-1:0] min_next(input logic [MIN_W-1:0] m);
        return (m == MIN_MAX) ? '0 : m + 1'b1;
    endfunction

    function automatic logic [HR_W-1:0] hr_next(input logic [HR_W-1:0] h);
        return (h == HR_MAX) ? HR_MIN : h + 1'b1;
    endfunction

    assign w_set = (mode == MODE_SET);

`ifdef EXT_TICK_EN
    assign w_tick = tick_1hz & ~w_set;
`else
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Held at zero in set mode so the first tick after leaving it is a full period away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        r_cnt <= '0;
        else if (w_set || r_cnt == CNT_LAST) r_cnt <= '0;
        else                               r_cnt <= r_cnt + 1'b1;
    end

    assign w_tick = ~w_set & (r_cnt == CNT_LAST);
`endif

    edge_rise u_rise_hr (
        .clk   (clk),
        .reset (reset),
        .in    (inc_hr),
        .rise  (w_rise_hr)
    );

    edge_rise u_rise_min (
        .clk   (clk),
        .reset (reset),
        .in    (inc_min),
        .rise  (w_rise_min)
    );

    assign w_sec_wrap = (r_sec == SEC_MAX);
    assign w_min_wrap = (r_min == MIN_MAX);

    // Button steps never carry; running carries ripple in one cycle so midnight wraps atomically.
    assign w_step_min = w_set ? w_rise_min : (w_tick & w_sec_wrap);
    assign w_step_hr  = w_set ? w_rise_hr  : (w_tick & w_sec_wrap & w_min_wrap);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sec      <= '0;
            r_min      <= '0;
            r_hr       <= HR_MAX;
            r_ap       <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            if (w_set)
                r_sec <= '0;
            else if (w_tick)
                r_sec <= w_sec_wrap ? '0 : r_sec + 1'b1;
            if (w_step_min)
                r_min <= min_next(r_min);
            if (w_step_hr) begin
                r_hr <= hr_next(r_hr);
                if (r_hr == HR_PRE_NOON)
                    r_ap <= ~r_ap;
            end
        end
    end

    assign sec      = r_sec;
    assign min      = r_min;
    assign hr       = r_hr;
    assign AP       = r_ap;
    assign sec_tick = r_sec_tick;

endmodule

// File: doc/time_keeper_12h.md
# time_keeper_12h

Free-running 12-hour timekeeper for the multimodal digital clock. Divides the system clock to a 1 Hz tick and maintains seconds, minutes and hours (1–12) plus the AM/PM flag. The AM/PM flag feeds the AM/PM seven-segment driver's `AP_i` input; the hour and minute values feed the digit decoders. In set mode the counters freeze and two push-button inputs step hours and minutes.

## Interface
- `TICK_DIV`, default 100_000_000: system clocks per 1 s tick; must be ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  2  display mode, same encoding the display stage uses:
  - 2'b01 = clock display
  - 2'b10 = set time
  - 2'b00 / 2'b11 = other modes
- `inc_hr`  in  1  hour-set button, synchronous level, already debounced.
- `inc_min`  in  1  minute-set button, synchronous level, already debounced.
- `sec`  out  6  seconds, 0–59.
- `min`  out  6  minutes, 0–59.
- `hr`  out  4  hours, 1–12, never 0.
- `AP`  out  1  0 = AM, 1 = PM; drives the display stage's `AP_i`.
- `sec_tick`  out  1  one-cycle pulse each time `sec` advances.

## Operation
- **Reset (`reset` = 0):** asynchronous.
  - `sec` = 0, `min` = 0, `hr` = 12, `AP` = 0, `sec_tick` = 0.
  - Prescaler = 0, button history registers = 0.
- **Prescaler:** counts 0..`TICK_DIV`-1. The tick is the cycle where count = `TICK_DIV`-1; the count then wraps to 0.
- **Running (`mode` ≠ 2'b10):** on each tick, time advances by one second.
  - `sec` 59→0 carries into `min`.
  - `min` 59→0 carries into `hr`.
  - `hr` 11→12 toggles `AP`.
  - `hr` 12→1 does not toggle `AP`.
  - Time keeps running in modes 00, 01 and 11. Buttons are ignored in these modes.
- **Set (`mode` = 2'b10):**
  - Prescaler is held at 0 and ticks are suppressed.
  - `sec` is forced to 0.
  - A rising edge on `inc_min` advances `min` by one; 59→0 with no hour carry.
  - A rising edge on `inc_hr` advances `hr` by one; 12→1, and 11→12 toggles `AP`.
  - Rising-edge detection: `inc_x` = 1 while the previous-cycle sample = 0. Holding a button gives exactly one step.
  - The button history registers update in every mode. A button already held when set mode is entered does not step.
- **Simultaneous events:**
  - `inc_hr` and `inc_min` edges in the same cycle both apply.
  - A tick and a mode change to set in the same cycle: set mode wins and the tick is dropped.
- **Leaving set mode:** counting resumes from `sec` = 0. The first tick comes a full `TICK_DIV` cycles later.

## Timing
- All outputs are registered.
- The time change is visible the cycle after the tick cycle or the cycle in which the button edge is sampled, i.e. 1-cycle latency.
- `sec_tick` is high for exactly the cycle in which the new `sec` value first appears. It never asserts in set mode.
- The tick period is exactly `TICK_DIV` clocks.
- A full-day wrap, 11:59:59 PM → 12:00:00 AM, completes in a single tick cycle. All fields and `AP` update together, with no intermediate values.
- Reset asserted mid-count clears all state immediately, independent of `clk`.

## Configuration
- **`EXT_TICK_EN` defined:**
  - Adds input port `tick_1hz` (1 bit, synchronous, one-cycle pulses).
  - Removes the internal prescaler; `TICK_DIV` is unused.
  - Each `tick_1hz` pulse acts as the tick.
  - In set mode, `tick_1hz` pulses are ignored.
  - On leaving set mode, the next `tick_1hz` pulse advances the time.
- **`EXT_TICK_EN` undefined:** internal prescaler as described above; no `tick_1hz` port.

## Structure
- **Shared package `clock_pkg`:**
  - Mode constants: MODE_CLOCK = 2'b01, MODE_SET = 2'b10.
  - Field-width constants: SEC_W = 6, MIN_W = 6, HR_W = 4.
  - Limits: SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 12, HR_MIN = 1.
- **Sub-module `edge_rise`:** one flop plus an AND gate; output `rise` = `in` & ~`q`. Instantiated twice, for `inc_hr` and `inc_min`.
- The hour/AM-PM update and the seconds/minutes chain stay in the top module.

## Test plan
- **Reset and first tick** (`TICK_DIV` = 4): release `reset`, mode 01 → 12:00:00 AM. After 4 clocks `sec` = 1 and `sec_tick` pulses once.
- **PM crossing and full-day wrap:** preset via set mode to 11:59 AM, then run 60 ticks → 12:00:00 PM with `AP` = 1.
  - Continue to 12:59:59 PM, one tick → 1:00:00 PM with `AP` unchanged.
  - Force to 11:59:59 PM, one tick → 12:00:00 AM with `AP` = 0.
- **Set mode:**
  - Mode 10 at 3:27:41 → `sec` = 0 the next cycle.
  - Hold `inc_min` high for 10 cycles → `min` = 28 only.
  - Three `inc_hr` pulses: 3→6.
  - Both buttons rising in the same cycle → `hr` and `min` each +1.
- **Frozen count in set mode:** stay in mode 10 for 3×`TICK_DIV` clocks → no change, `sec_tick` stays 0.
  - Return to mode 01 → first `sec_tick` exactly `TICK_DIV` clocks later.
- **Async reset mid-run:** assert `reset` between clock edges at 7:45:12 PM → outputs read 12:00:00 AM before the next edge.
- **`EXT_TICK_EN` build:** 5 `tick_1hz` pulses → `sec` = 5.
  - Pulses during mode 10 are ignored.
